// File: rtl/traffic_phase_scheduler.sv
// Traffic phase scheduler: main road / farm road intersection controller with
// a tick prescaler, per-phase timer, request latches and registered lamps.
// Optional pedestrian walk phase is built when the macro PED_REQ_EN is defined.
module traffic_phase_scheduler #(
    parameter int TICK_DIV  = 16,
    parameter int GREEN_MIN = 8,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int FARM_MAX  = 6,
    parameter int WALK_T    = 5
) (
    input  logic       blif_clk_net,
    input  logic       blif_reset_net,
    input  logic       FM,
    input  logic       TEST,
    input  logic       CLR,
`ifdef PED_REQ_EN
    input  logic       PED,
    output logic       WALK,
`endif
    output logic       GRN1,
    output logic       YLW1,
    output logic       RED1,
    output logic       GRN2,
    output logic       YLW2,
    output logic       RED2,
    output logic [2:0] PHASE
);

    typedef enum logic [2:0] {
        S_MG  = 3'd0,
        S_MY  = 3'd1,
        S_AR1 = 3'd2,
        S_FG  = 3'd3,
        S_FY  = 3'd4,
        S_AR2 = 3'd5,
        S_WK  = 3'd6
    } state_t;

    // Last timer value of each timed phase (a phase of N ticks ends at N-1).
    localparam logic [15:0] PRESC_LAST  = 16'(TICK_DIV - 1);
    localparam logic [15:0] GREEN_LAST  = 16'(GREEN_MIN - 1);
    localparam logic [15:0] YELLOW_LAST = 16'(YELLOW_T - 1);
    localparam logic [15:0] ALLRED_LAST = 16'(ALLRED_T - 1);
    localparam logic [15:0] FARM_LAST   = 16'(FARM_MAX - 1);
    localparam logic [15:0] WALK_LAST   = 16'(WALK_T - 1);

    // Lamp pattern order: {GRN1, YLW1, RED1, GRN2, YLW2, RED2}
    localparam logic [5:0] LAMPS_RST = 6'b100001;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_presc;
    logic [15:0] r_timer;
    logic        r_farm;
    logic        w_tick;
    logic        w_req;
    logic        w_farm_grant;
    logic        w_enter_fg;
    logic [5:0]  r_lamps;
    logic [2:0]  r_phase;

`ifdef PED_REQ_EN
    logic        r_ped;
    logic        r_last_ped;
    logic        r_walk;
    logic        w_enter_wk;
`endif

    function automatic logic [5:0] lamps_of(input state_t s);
        case (s)
            S_MG:    lamps_of = 6'b100001;
            S_MY:    lamps_of = 6'b010001;
            S_FG:    lamps_of = 6'b001100;
            S_FY:    lamps_of = 6'b001010;
            default: lamps_of = 6'b001001;
        endcase
    endfunction

    assign w_tick     = TEST || (r_presc == PRESC_LAST);
    assign w_enter_fg = (w_next == S_FG) && (r_state != S_FG);

`ifdef PED_REQ_EN
    assign w_enter_wk   = (w_next == S_WK) && (r_state != S_WK);
    assign w_req        = r_farm || r_ped;
    // Farm wins when it is the only request, or when both wait and the
    // pedestrian was served last.
    assign w_farm_grant = r_farm && (!r_ped || r_last_ped);
`else
    assign w_req        = r_farm;
    assign w_farm_grant = 1'b1;
`endif

    // Prescaler: free-running divider, parked at zero in test mode.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            r_presc <= '0;
        end else if (CLR || TEST || (r_presc == PRESC_LAST)) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    // Next-state decode: phases only advance on a tick.
    always_comb begin
        w_next = r_state;
        if (w_tick) begin
            case (r_state)
                S_MG:  if ((r_timer >= GREEN_LAST) && w_req) w_next = S_MY;
                S_MY:  if (r_timer == YELLOW_LAST) w_next = S_AR1;
                S_AR1: if (r_timer == ALLRED_LAST) w_next = w_farm_grant ? S_FG : S_WK;
                S_FG:  if (!FM || (r_timer == FARM_LAST)) w_next = S_FY;
                S_FY:  if (r_timer == YELLOW_LAST) w_next = S_AR2;
                S_AR2: if (r_timer == ALLRED_LAST) w_next = S_MG;
                S_WK:  if (r_timer == WALK_LAST) w_next = S_AR2;
                default: w_next = S_MG;
            endcase
        end
    end

    // State register and phase timer (cleared on entry, saturating in MG).
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            r_state <= S_MG;
            r_timer <= '0;
        end else if (CLR) begin
            r_state <= S_MG;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_timer <= '0;
            end else if (w_tick && !((r_state == S_MG) && (r_timer >= GREEN_LAST))) begin
                r_timer <= r_timer + 16'd1;
            end
        end
    end

    // Farm request latch: clear on FG entry beats a same-cycle set.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            r_farm <= 1'b0;
        end else if (CLR || w_enter_fg) begin
            r_farm <= 1'b0;
        end else if (FM && (r_state != S_FG)) begin
            r_farm <= 1'b1;
        end
    end

`ifdef PED_REQ_EN
    // Pedestrian latch and last-served flag for round-robin arbitration.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            r_ped      <= 1'b0;
            r_last_ped <= 1'b1;
        end else if (CLR) begin
            r_ped      <= 1'b0;
            r_last_ped <= 1'b1;
        end else begin
            if (w_enter_wk) begin
                r_ped <= 1'b0;
            end else if (PED) begin
                r_ped <= 1'b1;
            end
            if (w_enter_fg) begin
                r_last_ped <= 1'b0;
            end else if (w_enter_wk) begin
                r_last_ped <= 1'b1;
            end
        end
    end
`endif

    // Lamps and phase code registered from the next state (no extra latency).
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            r_lamps <= LAMPS_RST;
            r_phase <= S_MG;
`ifdef PED_REQ_EN
            r_walk  <= 1'b0;
`endif
        end else if (CLR) begin
            r_lamps <= LAMPS_RST;
            r_phase <= S_MG;
`ifdef PED_REQ_EN
            r_walk  <= 1'b0;
`endif
        end else begin
            r_lamps <= lamps_of(w_next);
            r_phase <= w_next;
`ifdef PED_REQ_EN
            r_walk  <= (w_next == S_WK);
`endif
        end
    end

    assign {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = r_lamps;
    assign PHASE = r_phase;
`ifdef PED_REQ_EN
    assign WALK = r_walk;
`endif

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: a phase-duration model is
// compared against the lamps/PHASE every cycle, and directed scenarios pin
// phase lengths with hand-computed values. PED_REQ_EN enables walk scenarios.
module tb_traffic_phase_scheduler;

    localparam int P_TICK   = 16;
    localparam int P_GREEN  = 8;
    localparam int P_YELLOW = 3;
    localparam int P_ALLRED = 1;
    localparam int P_FARM   = 6;
    localparam int P_WALK   = 5;

    logic       clk;
    logic       rst_n;
    logic       FM;
    logic       TEST;
    logic       CLR;
    logic       ped_in;
    logic       walk_o;
    logic       GRN1, YLW1, RED1, GRN2, YLW2, RED2;
    logic [2:0] PHASE;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    traffic_phase_scheduler #(
        .TICK_DIV (P_TICK),
        .GREEN_MIN(P_GREEN),
        .YELLOW_T (P_YELLOW),
        .ALLRED_T (P_ALLRED),
        .FARM_MAX (P_FARM),
        .WALK_T   (P_WALK)
    ) dut (
        .blif_clk_net  (clk),
        .blif_reset_net(rst_n),
        .FM            (FM),
        .TEST          (TEST),
        .CLR           (CLR),
`ifdef PED_REQ_EN
        .PED           (ped_in),
        .WALK          (walk_o),
`endif
        .GRN1          (GRN1),
        .YLW1          (YLW1),
        .RED1          (RED1),
        .GRN2          (GRN2),
        .YLW2          (YLW2),
        .RED2          (RED2),
        .PHASE         (PHASE)
    );

`ifndef PED_REQ_EN
    assign walk_o = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Tracks the phase, the number of whole ticks spent in it, and requests.
    typedef struct packed {
        int phase;
        int ticks;
        int presc;
        bit farm;
        bit ped;
        bit last_ped;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t m_reset();
        mstate_t r;
        r.phase = 0; r.ticks = 0; r.presc = 0;
        r.farm = 0; r.ped = 0; r.last_ped = 1;
        return r;
    endfunction

    function automatic mstate_t m_next(mstate_t c, bit fm, bit test, bit clr, bit ped);
        mstate_t n;
        bit tick;
        bit pend;
        int np;
        if (clr) return m_reset();
        n = c;
        tick = test || (c.presc == P_TICK - 1);
        n.presc = (test || tick) ? 0 : c.presc + 1;
        pend = c.farm || c.ped;
        np = c.phase;
        if (tick) begin
            case (c.phase)
                0: if (c.ticks + 1 >= P_GREEN && pend) np = 1;
                1: if (c.ticks + 1 == P_YELLOW) np = 2;
                2: if (c.ticks + 1 == P_ALLRED) begin
`ifdef PED_REQ_EN
                       np = (c.farm && (!c.ped || c.last_ped)) ? 3 : 6;
`else
                       np = 3;
`endif
                   end
                3: if (!fm || c.ticks + 1 == P_FARM) np = 4;
                4: if (c.ticks + 1 == P_YELLOW) np = 5;
                5: if (c.ticks + 1 == P_ALLRED) np = 0;
                6: if (c.ticks + 1 == P_WALK) np = 5;
                default: np = 0;
            endcase
        end
        n.ticks = (np != c.phase) ? 0 : (tick ? c.ticks + 1 : c.ticks);
        n.farm  = (np == 3 && c.phase != 3) ? 1'b0 : (c.farm || (fm && c.phase != 3));
`ifdef PED_REQ_EN
        n.ped   = (np == 6 && c.phase != 6) ? 1'b0 : (c.ped || ped);
`else
        n.ped   = 1'b0;
        if (ped) n.ped = 1'b0;
`endif
        if (np == 3 && c.phase != 3) n.last_ped = 1'b0;
        if (np == 6 && c.phase != 6) n.last_ped = 1'b1;
        n.phase = np;
        return n;
    endfunction

    // {GRN1,YLW1,RED1,GRN2,YLW2,RED2,WALK} for a phase code
    function automatic logic [6:0] lamps_exp(int ph);
        case (ph)
            0: return 7'b1000010;
            1: return 7'b0100010;
            3: return 7'b0011000;
            4: return 7'b0010100;
            6: return 7'b0010011;
            default: return 7'b0010010;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= m_reset();
        else        m <= m_next(m, FM, TEST, CLR, ped_in);
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [9:0] act;
        logic [9:0] expv;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                act  = {PHASE, GRN1, YLW1, RED1, GRN2, YLW2, RED2, walk_o};
                expv = {m.phase[2:0], lamps_exp(m.phase)};
                n_checks++;
                if (act !== expv) begin
                    n_errors++;
                    $display("FAIL model_cmp t=%0t got %b expected %b", $time, act, expv);
                end
                n_checks++;
                if ($countones({GRN1, YLW1, RED1}) != 1 || $countones({GRN2, YLW2, RED2}) != 1
                    || (GRN1 && GRN2)) begin
                    n_errors++;
                    $display("FAIL lamp_invariant t=%0t got main=%b farm=%b required one lamp each",
                             $time, {GRN1, YLW1, RED1}, {GRN2, YLW2, RED2});
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Count negedge samples that the current PHASE persists; returns at the
    // first sample showing a different phase.
    task automatic measure(output int len, output int ph);
        ph  = int'(PHASE);
        len = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (int'(PHASE) != ph) return;
            len++;
        end
        n_checks++;
        n_errors++;
        $display("FAIL measure_timeout: phase %0d held for %0d cycles, required a change", ph, len);
    endtask

    task automatic wait_phase(input int ph, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (int'(PHASE) == ph) return;
            @(negedge clk);
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_phase_timeout: got phase %0d required %0d", PHASE, ph);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_seq(input string tag, input int n, input int eph[10], input int elen[10]);
        int l;
        int p;
        for (int k = 0; k < n; k++) begin
            measure(l, p);
            check($sformatf("%s_phase%0d", tag, k), p, eph[k]);
            check($sformatf("%s_len%0d", tag, k), l, elen[k]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int bad;
        int l;
        int p;
        int eph[10];
        int elen[10];
        rst_n = 1'b1; FM = 1'b0; TEST = 1'b0; CLR = 1'b0; ped_in = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("reset_phase", int'(PHASE), 0);
        check("reset_lamps", int'({GRN1, YLW1, RED1, GRN2, YLW2, RED2, walk_o}), int'(7'b1000010));
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: no requests, main green holds.
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (PHASE != 3'd0 || !GRN1 || !RED2) bad++;
        end
        check("idle_mg_hold", bad, 0);

        // Single farm pulse in test mode.
        TEST = 1'b1;
        do_reset();
        FM = 1'b1;
        fork begin @(negedge clk); FM = 1'b0; end join_none
        eph  = '{0, 1, 2, 3, 4, 5, 0, 0, 0, 0};
        elen = '{8, 3, 1, 1, 3, 1, 0, 0, 0, 0};
        run_seq("pulse", 6, eph, elen);
        check("pulse_back_mg", int'(PHASE), 0);

        // Farm sensor held: FG times out at FARM_MAX, MG runs full minimum.
        do_reset();
        FM = 1'b1;
        eph  = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3};
        elen = '{8, 3, 1, 6, 3, 1, 8, 3, 1, 6};
        run_seq("held", 10, eph, elen);
        FM = 1'b0;

`ifdef PED_REQ_EN
        // Farm and pedestrian together: farm first, then walk.
        do_reset();
        FM = 1'b1; ped_in = 1'b1;
        fork begin @(negedge clk); FM = 1'b0; ped_in = 1'b0; end join_none
        eph  = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 0};
        elen = '{8, 3, 1, 1, 3, 1, 8, 3, 1, 0};
        run_seq("ped", 9, eph, elen);
        check("ped_walk_on", int'(walk_o), 1);
        check("ped_reds", int'({RED1, RED2}), 3);
        measure(l, p);
        check("ped_wk_phase", p, 6);
        check("ped_wk_len", l, 5);
        check("ped_after_wk", int'(PHASE), 5);
`endif

        // Synchronous clear during FG, with FM still high at the clear edge.
        do_reset();
        FM = 1'b1;
        wait_phase(3, 100);
        CLR = 1'b1;
        @(negedge clk);
        CLR = 1'b0; FM = 1'b0;
        check("clr_phase", int'(PHASE), 0);
        check("clr_lamps", int'({GRN1, YLW1, RED1, GRN2, YLW2, RED2}), int'(6'b100001));
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (PHASE != 3'd0) bad++;
        end
        check("clr_fg_hold", bad, 0);
        // Pending farm request is dropped by a clear.
        FM = 1'b1;
        @(negedge clk);
        FM = 1'b0; CLR = 1'b1;
        @(negedge clk);
        CLR = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (PHASE != 3'd0) bad++;
        end
        check("clr_latch_hold", bad, 0);

        // Asynchronous reset mid-FY with the prescaler running.
        TEST = 1'b0;
        do_reset();
        FM = 1'b1;
        wait_phase(4, 600);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_phase", int'(PHASE), 0);
        check("async_lamps", int'({GRN1, YLW1, RED1, GRN2, YLW2, RED2}), int'(6'b100001));
        @(negedge clk);
        rst_n = 1'b1;
        measure(l, p);
        check("async_mg_phase", p, 0);
        check("async_mg_len", l, P_GREEN * P_TICK);
        FM = 1'b0;

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
